bus_transfer_executor: RTL
==========================

// Module: bus_transfer_executor
// PURPOSE
//  Datapath/responder end of the register-bus control interface: consumes the
//  load/select control word (ldr_1..3, sel_1, sel_2) from the bus controller and
//  performs the transfers: data_in->R1, R1->R2, R2->R3.
//  Also checks the control-word stream against the 3-phase frame protocol,
//  flags illegal or out-of-order words, and counts completed frames.
// PARAMETERS
//  WIDTH        8   data/bus/register width
//  ERR_CNT_W    8   error counter width (saturating)
//  FRAME_CNT_W  16  completed-frame counter width (wrapping)
// PORTS
//  clk          in   1            clock; all state updates on rising edge
//  rst          in   1            synchronous reset, active-low
//  data_in      in   WIDTH        external bus source
//  ldr_1        in   1            load R1 from bus
//  ldr_2        in   1            load R2 from bus
//  ldr_3        in   1            load R3 from bus
//  sel_1        in   1            1: bus=data_in; 0: bus from sel_2 mux
//  sel_2        in   2            00:R1 01:R2 10:R3 11:zero (used when sel_1=0)
//  clr_err      in   1            clears err_sticky and err_cnt
//  bus          out  WIDTH        combinational bus value (observation)
//  r1,r2,r3     out  WIDTH        register contents
//  frame_done   out  1            1-cycle pulse: valid frame completed
//  err_illegal  out  1            1-cycle pulse: illegal control word
//  err_seq      out  1            1-cycle pulse: legal word out of sequence
//  err_sticky   out  1            set by any error, held until clr_err/reset
//  err_cnt      out  ERR_CNT_W    error count, saturates at all-ones
//  frame_cnt    out  FRAME_CNT_W  completed frames, wraps to 0
//  trk_state    out  2            tracker state: 0 HUNT, 1 EXP1, 2 EXP2
// BEHAVIOUR
//  - Reset (rst==0 at posedge): r1/r2/r3, counters, pulses, err_sticky = 0;
//    tracker = HUNT. Reset mid-frame discards the frame; no frame_done.
//  - Controls change on the controller's falling edge; sampled at rising edge.
//  - Word decode {ldr_1,ldr_2,ldr_3,sel_1,sel_2}: IDLE=000_0_xx,
//    W0=100_1_00, W1=010_0_00, W2=001_0_01. Any other word is ILLEGAL.
//  - Legal words perform their load at the edge they are sampled (0 latency
//    into r*). ILLEGAL words perform no load; err_illegal pulses next cycle.
//  - Tracker transitions (word sampled -> next state):
//    HUNT: W0->EXP1; IDLE->HUNT; W1/W2->HUNT + err_seq
//    EXP1: W1->EXP2; IDLE->EXP1 (stall allowed); W0->EXP1 + err_seq (restart);
//          W2->HUNT + err_seq
//    EXP2: W2->HUNT + frame_done, frame_cnt+1; IDLE->EXP2; W0->EXP1 + err_seq;
//          W1->HUNT + err_seq
//    any state: ILLEGAL->HUNT + err_illegal
//  - Pulses are registered: asserted the cycle after the causing edge, held 1 cycle.
//  - Out-of-sequence legal words still load their register.
//  - err_cnt +1 per error event (err_illegal and err_seq never both in one cycle);
//    holds at 2^ERR_CNT_W-1. clr_err: err_sticky=0, err_cnt=0; if an error
//    occurs in the same cycle, error wins: err_sticky=1, err_cnt=1.
//  - frame_cnt wraps from 2^FRAME_CNT_W-1 to 0 without error.
// TESTING
//  1 rst=0 two cycles with ldr_* toggling -> r1..r3=0, trk_state=0, no pulses.
//  2 W0,W1,W2 with data_in=8'hA5 at W0 -> r1=r2=r3=8'hA5; frame_done 1 cycle;
//    frame_cnt=1.
//  3 W0,IDLE,IDLE,W1,W2 -> stall accepted, frame_done once, err_cnt=0.
//  4 W0 then word 110_0_00 -> no load, err_illegal pulse, trk_state=0, err_cnt=1.
//  5 W0,W2 -> r3 loaded from R2, err_seq pulse, trk_state=0; then clr_err with
//    W1 in HUNT the same cycle -> err_sticky=1, err_cnt=1.
//  6 force err_cnt to 255 via 256 bad words -> holds 255; 65536 frames -> frame_cnt=0.

Source files
------------

// File: rtl/bus_transfer_executor.sv
// bus_transfer_executor: responder end of the register-bus control interface.
// Performs data_in->R1, R1->R2 and R2->R3 transfers from the control word.
// Checks the word stream against the 3-phase W0/W1/W2 frame protocol, raises
// error pulses, and counts errors (saturating) and completed frames (wrapping).
module bus_transfer_executor #(
  parameter int WIDTH       = 8,
  parameter int ERR_CNT_W   = 8,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   ldr_1,
  input  logic                   ldr_2,
  input  logic                   ldr_3,
  input  logic                   sel_1,
  input  logic [1:0]             sel_2,
  input  logic                   clr_err,
  output logic [WIDTH-1:0]       bus,
  output logic [WIDTH-1:0]       r1,
  output logic [WIDTH-1:0]       r2,
  output logic [WIDTH-1:0]       r3,
  output logic                   frame_done,
  output logic                   err_illegal,
  output logic                   err_seq,
  output logic                   err_sticky,
  output logic [ERR_CNT_W-1:0]   err_cnt,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [1:0]             trk_state
);

  localparam logic [1:0] HUNT = 2'd0;
  localparam logic [1:0] EXP1 = 2'd1;
  localparam logic [1:0] EXP2 = 2'd2;

  localparam logic [5:0] WORD_W0 = 6'b100100;
  localparam logic [5:0] WORD_W1 = 6'b010000;
  localparam logic [5:0] WORD_W2 = 6'b001001;

  logic [5:0] word_p0;
  logic       is_idle_p0;
  logic       is_w0_p0;
  logic       is_w1_p0;
  logic       is_w2_p0;
  logic       is_ill_p0;
  logic [1:0] nxt_state_p0;
  logic       seq_err_p0;
  logic       frm_ok_p0;
  logic       err_ev_p0;

  // Error counter increment that sticks at all-ones.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    if (&v) return v;
    return v + ERR_CNT_W'(1);
  endfunction

  assign word_p0 = {ldr_1, ldr_2, ldr_3, sel_1, sel_2};

  // Classify the sampled control word; IDLE ignores sel_2.
  always_comb begin
    is_idle_p0 = (word_p0[5:2] == 4'b0000);
    is_w0_p0   = (word_p0 == WORD_W0);
    is_w1_p0   = (word_p0 == WORD_W1);
    is_w2_p0   = (word_p0 == WORD_W2);
    is_ill_p0  = !(is_idle_p0 || is_w0_p0 || is_w1_p0 || is_w2_p0);
  end

  // Bus source mux: external data or one of the registers (11 drives zero).
  always_comb begin
    bus = '0;
    if (sel_1) begin
      bus = data_in;
    end else begin
      case (sel_2)
        2'b00:   bus = r1;
        2'b01:   bus = r2;
        2'b10:   bus = r3;
        default: bus = '0;
      endcase
    end
  end

  // Frame tracker next state and the events the sampled word causes.
  always_comb begin
    nxt_state_p0 = trk_state;
    seq_err_p0   = 1'b0;
    frm_ok_p0    = 1'b0;
    if (is_ill_p0) begin
      nxt_state_p0 = HUNT;
    end else if (is_w0_p0) begin
      // W0 always (re)starts a frame; only legal from HUNT.
      nxt_state_p0 = EXP1;
      seq_err_p0   = (trk_state != HUNT);
    end else if (is_w1_p0) begin
      if (trk_state == EXP1) begin
        nxt_state_p0 = EXP2;
      end else begin
        nxt_state_p0 = HUNT;
        seq_err_p0   = 1'b1;
      end
    end else if (is_w2_p0) begin
      nxt_state_p0 = HUNT;
      if (trk_state == EXP2) frm_ok_p0 = 1'b1;
      else                   seq_err_p0 = 1'b1;
    end else if (trk_state == 2'd3) begin
      nxt_state_p0 = HUNT;
    end
    err_ev_p0 = is_ill_p0 || seq_err_p0;
  end

  // Register transfers: legal words load at the sampling edge, illegal ones never do.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
    end else if (!is_ill_p0) begin
      if (ldr_1) r1 <= bus;
      if (ldr_2) r2 <= bus;
      if (ldr_3) r3 <= bus;
    end
  end

  // Tracker state, registered event pulses and counters; an error beats clr_err.
  always_ff @(posedge clk) begin
    if (!rst) begin
      trk_state   <= HUNT;
      frame_done  <= 1'b0;
      err_illegal <= 1'b0;
      err_seq     <= 1'b0;
      err_sticky  <= 1'b0;
      err_cnt     <= '0;
      frame_cnt   <= '0;
    end else begin
      trk_state   <= nxt_state_p0;
      frame_done  <= frm_ok_p0;
      err_illegal <= is_ill_p0;
      err_seq     <= seq_err_p0;
      if (err_ev_p0) begin
        err_sticky <= 1'b1;
        err_cnt    <= clr_err ? ERR_CNT_W'(1) : sat_inc(err_cnt);
      end else if (clr_err) begin
        err_sticky <= 1'b0;
        err_cnt    <= '0;
      end
      if (frm_ok_p0) frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
  end

endmodule
